// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - Hack instruction ROM loader with byte-stream writer and CPU fetch port
//
// Purpose:
//   Receives a program as a byte stream (16-bit big-endian length, then
//   big-endian 16-bit instruction words), writes the words into an internal
//   ROM, and keeps the CPU in reset until a complete program is present.
//   The CPU fetch port reads the ROM combinationally; words beyond the
//   loaded program read as zero.
//
// Ports:
//   clk         system clock (rising edge)
//   rst_n       asynchronous active-low reset
//   load_start  one-cycle pulse, begins or restarts a program load
//   rx_data     program byte
//   rx_valid    rx_data is valid
//   rx_ready    loader accepts a byte this cycle
//   pc          CPU fetch address
//   instr       instruction at pc, zero outside the loaded program
//   cpu_reset   active-high reset to the CPU core
//   load_done   program loaded, CPU released
//   load_error  declared length exceeds ROM depth
//   word_count  number of words currently loaded

module hack_rom_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [14:0]       pc,
  output logic [15:0]       instr,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       len;
  logic [7:0]        hold;
  logic [ADDR_W-1:0] wptr;
  logic              accept;
  logic [15:0]       len_full;
  logic [16:0]       count_inc;
  logic              cpu_reset_next;
  logic              load_done_next;
  logic              load_error_next;

  logic [15:0]       rom [DEPTH];

  // Byte handshake: only the four receiving states take bytes, and a
  // load_start cycle never consumes a byte.
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: rx_ready = 1'b1;
      default:                                  rx_ready = 1'b0;
    endcase
    if (load_start) rx_ready = 1'b0;
  end

  assign accept    = rx_valid && rx_ready;
  // Length as it will be once the current (low) byte lands.
  assign len_full  = {len[15:8], rx_data};
  // Count after the word being written in DATA_LO, widened so the
  // comparison against the 16-bit length never truncates.
  assign count_inc = 17'(word_count) + 17'd1;

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    if (load_start) begin
      state_next = S_LEN_HI;
    end else begin
      case (state)
        S_LEN_HI: begin
          if (accept) state_next = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (accept) begin
            if (len_full == 16'd0)             state_next = S_DONE;
            else if (17'(len_full) > DEPTH_W)  state_next = S_ERR;
            else                               state_next = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (accept) state_next = S_DATA_LO;
        end
        S_DATA_LO: begin
          if (accept) begin
            if (count_inc == 17'(len)) state_next = S_DONE;
            else                       state_next = S_DATA_HI;
          end
        end
        default: state_next = state;
      endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself and never glitch.
    cpu_reset_next  = (state_next != S_DONE);
    load_done_next  = (state_next == S_DONE);
    load_error_next = (state_next == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      hold       <= '0;
      wptr       <= '0;
      word_count <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_next;
      cpu_reset  <= cpu_reset_next;
      load_done  <= load_done_next;
      load_error <= load_error_next;
      if (load_start) begin
        len        <= '0;
        wptr       <= '0;
        word_count <= '0;
      end else if (accept) begin
        case (state)
          S_LEN_HI:  len[15:8] <= rx_data;
          S_LEN_LO:  len[7:0]  <= rx_data;
          S_DATA_HI: hold      <= rx_data;
          S_DATA_LO: begin
            wptr       <= wptr + 1'b1;
            word_count <= word_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // ROM array has no reset; stale contents are hidden by the fetch mask.
  always_ff @(posedge clk) begin
    if (accept && state == S_DATA_LO && !load_start) begin
      rom[wptr] <= {hold, rx_data};
    end
  end

  // pc < word_count also guarantees the upper pc bits are zero, since
  // word_count never exceeds the ROM depth.
  always_comb begin
    instr = 16'h0000;
    if (17'(pc) < 17'(word_count)) instr = rom[pc[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb/tb_hack_rom_loader.sv - self-checking bench for hack_rom_loader

module tb_hack_rom_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [14:0] pc;
  logic [15:0] instr;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [8:0]  word_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stream[$];
  logic [15:0] exp_rom[256];
  int          exp_count;
  bit          exp_done;
  bit          exp_err;

  hack_rom_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .pc         (pc),
    .instr      (instr),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret a complete byte stream by the framing rules.
  task automatic model_stream();
    int n;
    n = (int'(stream[0]) << 8) | int'(stream[1]);
    exp_done  = 0;
    exp_err   = 0;
    exp_count = 0;
    if (n == 0) begin
      exp_done = 1;
    end else if (n > 256) begin
      exp_err = 1;
    end else begin
      for (int i = 0; i < n; i++) exp_rom[i] = {stream[2 + 2*i], stream[3 + 2*i]};
      exp_count = n;
      exp_done  = 1;
    end
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      errors++;
      $display("FAIL send_byte_timeout: rx_ready=%0b required 1", rx_ready);
    end
    checks++;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int maxgap);
    foreach (stream[i]) send_byte(stream[i], $urandom_range(0, maxgap));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc = 15'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %0b want 1", cpu_reset); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %0b want 0", load_done); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error: got %0b want 0", load_error); end
    checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %0b want 0", rx_ready); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    logic [7:0] bytes [8];
    bytes = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h00, 8'h00};
    pulse_load_start();
    for (int i = 0; i < 8; i++) begin
      rx_data = bytes[i]; rx_valid = 1'b1;
      @(negedge clk);
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL normal_rx_ready[%0d]: got %0b want 1", i, rx_ready); end
      if (i == 7) begin
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL normal_cpu_reset_before: got %0b want 1", cpu_reset); end
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL normal_cpu_reset_after: got %0b want 0", cpu_reset); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL normal_load_done: got %0b want 1", load_done); end
    checks++; if (word_count !== 9'd3) begin errors++; $display("FAIL normal_word_count: got %0d want 3", word_count); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL normal_rx_ready_done: got %0b want 0", rx_ready); end
    pc = 15'd0; #1;
    checks++; if (instr !== 16'h0005) begin errors++; $display("FAIL normal_pc0: got %h want 0005", instr); end
    pc = 15'd1; #1;
    checks++; if (instr !== 16'hEC10) begin errors++; $display("FAIL normal_pc1: got %h want ec10", instr); end
    pc = 15'd2; #1;
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL normal_pc2: got %h want 0000", instr); end
    pc = 15'd3; #1;
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL normal_pc3: got %h want 0000", instr); end
    @(posedge clk); #1;
  endtask

  // Random programs with random idle gaps; the first pass uses the fixed
  // three-word program with a strict valid-on/valid-off pattern.
  task automatic test_random_gaps();
    int n;
    for (int iter = 0; iter < 4; iter++) begin
      stream.delete();
      if (iter == 0) begin
        stream = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h00, 8'h00};
      end else begin
        n = $urandom_range(1, 40);
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom));
      end
      model_stream();
      pulse_load_start();
      if (iter == 0) foreach (stream[i]) send_byte(stream[i], 1);
      else send_stream(3);
      @(negedge clk);
      checks++; if (word_count !== 9'(exp_count)) begin errors++; $display("FAIL gaps_word_count[%0d]: got %0d want %0d", iter, word_count, exp_count); end
      checks++; if (load_done !== exp_done) begin errors++; $display("FAIL gaps_load_done[%0d]: got %0b want %0b", iter, load_done, exp_done); end
      checks++; if (cpu_reset !== !exp_done) begin errors++; $display("FAIL gaps_cpu_reset[%0d]: got %0b want %0b", iter, cpu_reset, !exp_done); end
      for (int a = 0; a <= exp_count; a++) begin
        pc = 15'(a); #1;
        if (a < exp_count) begin
          checks++; if (instr !== exp_rom[a]) begin errors++; $display("FAIL gaps_rom[%0d][%0d]: got %h want %h", iter, a, instr, exp_rom[a]); end
        end else begin
          checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL gaps_beyond[%0d]: got %h want 0000", iter, instr); end
        end
      end
      pc = 15'h4000; #1;
      checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL gaps_high_pc[%0d]: got %h want 0000", iter, instr); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_len();
    pulse_load_start();
    send_byte(8'h00, 0);
    @(negedge clk);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %0b want 0", load_done); end
    @(posedge clk); #1;
    send_byte(8'h00, 0);
    @(negedge clk);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL zero_load_done: got %0b want 1", load_done); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL zero_cpu_reset: got %0b want 0", cpu_reset); end
    checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL zero_word_count: got %0d want 0", word_count); end
    for (int a = 0; a < 4; a++) begin
      pc = 15'(a); #1;
      checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL zero_instr[%0d]: got %h want 0000", a, instr); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    pulse_load_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL ovf_load_error: got %0b want 1", load_error); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL ovf_cpu_reset: got %0b want 1", cpu_reset); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL ovf_rx_ready: got %0b want 0", rx_ready); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL ovf_load_done: got %0b want 0", load_done); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    pulse_load_start();
    @(negedge clk);
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", load_error); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL ovf_len_hi_ready: got %0b want 1", rx_ready); end
    @(posedge clk); #1;
  endtask

  // Largest legal program: exactly the ROM depth.
  task automatic test_max_len();
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    for (int i = 0; i < 512; i++) stream.push_back(8'($urandom));
    model_stream();
    pulse_load_start();
    send_stream(0);
    @(negedge clk);
    checks++; if (word_count !== 9'd256) begin errors++; $display("FAIL max_word_count: got %0d want 256", word_count); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL max_load_done: got %0b want 1", load_done); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL max_load_error: got %0b want 0", load_error); end
    foreach (exp_rom[a]) begin
      pc = 15'(a); #1;
      checks++; if (instr !== exp_rom[a]) begin errors++; $display("FAIL max_rom[%0d]: got %h want %h", a, instr, exp_rom[a]); end
    end
    pc = 15'd256; #1;
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL max_pc256: got %h want 0000", instr); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart();
    pulse_load_start();
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL restart_rx_ready: got %0b want 0", rx_ready); end
    @(posedge clk); #1;
    load_start = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL restart_word_count: got %0d want 0", word_count); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL restart_cpu_reset: got %0b want 1", cpu_reset); end
    pc = 15'd0; #1;
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL restart_masked: got %h want 0000", instr); end
    @(posedge clk); #1;
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    @(negedge clk);
    pc = 15'd0; #1;
    checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL restart_instr: got %h want 1234", instr); end
    checks++; if (word_count !== 9'd1) begin errors++; $display("FAIL restart_count: got %0d want 1", word_count); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL restart_done: got %0b want 1", load_done); end
    pc = 15'd1; #1;
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL restart_stale: got %h want 0000", instr); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    pulse_load_start();
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    // Now waiting for a low byte; drop reset between edges.
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL areset_cpu_reset: got %0b want 1", cpu_reset); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL areset_load_done: got %0b want 0", load_done); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL areset_rx_ready: got %0b want 0", rx_ready); end
    checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL areset_word_count: got %0d want 0", word_count); end
    pc = 15'd0; #1;
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL areset_instr: got %h want 0000", instr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_random_gaps();
    test_zero_len();
    test_overflow();
    test_max_len();
    test_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
Writer side of the Hack instruction-memory interface. Accepts a program as a byte stream over a valid/ready handshake and assembles big-endian 16-bit instructions into an internal word ROM. Serves the CPU fetch port (pc in, instr out) and holds the CPU in reset until a complete program has been loaded. Sits between a host/UART byte source and the hack CPU core.

Parameters:
ADDR_W, 8, ROM address width; depth = 2**ADDR_W words (default 256)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  single-cycle pulse: begin (or restart) a program load
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
pc  input  15  CPU fetch address
instr  output  16  instruction at pc (combinational read)
cpu_reset  output  1  active-high reset to the CPU core
load_done  output  1  program loaded; CPU released
load_error  output  1  declared length exceeded ROM depth
word_count  output  ADDR_W+1  number of words currently loaded

Behaviour:
- Reset (rst_n=0, async): state IDLE, word_count=0, internal length=0, write pointer=0, cpu_reset=1, load_done=0, load_error=0. ROM array contents are not reset; instr masking (below) makes them invisible.
- Byte accept: on rising clk when rx_valid && rx_ready. rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, and forced 0 combinationally while load_start=1.
- Stream format: 2-byte length N (high byte first), then N words, each high byte then low byte.
- States and transitions:
  - IDLE: wait; load_start -> LEN_HI.
  - LEN_HI: accept byte -> len[15:8], -> LEN_LO.
  - LEN_LO: accept byte -> len[7:0]; if N=0 -> DONE; if N > 2**ADDR_W -> ERR; else -> DATA_HI.
  - DATA_HI: accept byte into hold register -> DATA_LO.
  - DATA_LO: accept byte; write {hold, byte} to ROM[wptr]; wptr++, word_count++; if word_count reaches N -> DONE else -> DATA_HI.
  - DONE: cpu_reset=0, load_done=1; stays until load_start or reset.
  - ERR: load_error=1, cpu_reset=1; stays until load_start or reset.
- load_start in any state (including mid-load, DONE, ERR): next cycle state=LEN_HI, wptr=0, word_count=0, load_done=0, load_error=0, cpu_reset=1. No byte is accepted in the load_start cycle.
- cpu_reset=1 in every state except DONE; deasserts in the cycle after the final low byte is accepted (registered outputs).
- Fetch port: instr = ROM[pc[ADDR_W-1:0]] combinationally when pc < word_count and pc[14:ADDR_W]==0; otherwise 16'h0000. Reads are valid in every state; a word written on edge k is readable after edge k.
- Counters sized ADDR_W+1 so N = 2**ADDR_W is representable; no wrap-around occurs because N > depth is rejected.
- rx_valid with rx_ready=0 (IDLE/DONE/ERR): byte ignored, not buffered.
- Reset mid-load: immediate IDLE; partial program discarded (word_count=0).

Test Plan:
- Normal load: load_start, bytes 00 03 | 00 05 | EC 10 | 00 00 with rx_valid held 1 -> rx_ready high for 8 cycles, word_count=3, load_done=1, cpu_reset falls one cycle after last byte; pc=0/1/2 give 0005/EC10/0000, pc=3 gives 0000.
- Backpressure/gaps: same stream with rx_valid toggling 1,0,1,0 -> identical final ROM contents and word_count=3; no byte lost or duplicated.
- Zero length: load_start, 00 00 -> DONE two accepted bytes later, word_count=0, instr=0000 for all pc, cpu_reset=0.
- Overflow: ADDR_W=8, length 01 01 (257) -> load_error=1, cpu_reset=1, rx_ready=0; subsequent load_start clears error and returns to LEN_HI.
- Restart mid-load: 00 04 then two words, then load_start asserted together with rx_valid -> that byte not accepted, word_count=0; fresh 00 01 12 34 -> instr@pc0=1234, word_count=1.
- Async reset mid-load: rst_n low between clock edges during DATA_LO -> outputs immediately cpu_reset=1, load_done=0, rx_ready=0, word_count=0.
